// File: rtl/i2c_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_regfile
// Brief    : Oversampled I2C target with glitch filter, START/repeated START/
//            STOP detection, device address match and burst access to an
//            external byte-wide register file through an auto-incrementing
//            register pointer. Optional clock stretching while read data loads.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_regfile #(
    parameter int                       ADDRESSLENGTH = 7,
    parameter logic [ADDRESSLENGTH-1:0] SLAVE_ADDR    = 7'h42,
    parameter int                       PTRW          = 4,
    parameter int                       FILTER        = 3,
    parameter int                       STRETCH       = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            scl_in,
    input  logic            sda_in,
    output logic            sda_oe,
    output logic            scl_oe,
    output logic [PTRW-1:0] reg_addr,
    output logic [7:0]      reg_wr_data,
    output logic            reg_wr_en,
    output logic            reg_rd_en,
    input  logic [7:0]      reg_rd_data,
    output logic            selected
);

    // Shift register must hold either the address+R/W word or one data byte
    localparam int c_sw = (ADDRESSLENGTH + 1 > 8) ? ADDRESSLENGTH + 1 : 8;
    localparam int c_fw = $clog2(FILTER + 1);
    localparam logic [c_fw-1:0] c_fmax      = c_fw'(FILTER - 1);
    localparam logic [3:0]      c_addr_bits = 4'(ADDRESSLENGTH + 1);
    localparam logic            c_stretch   = (STRETCH != 0);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ACK_ADDR, S_PTR, S_ACK_PTR,
        S_WRITE, S_ACK_WR, S_READ, S_MACK, S_WAIT
    } state_t;

    // Index 1 carries Scl, index 0 carries Sda
    logic [1:0]      r_sync1, r_sync2, r_filt, r_prev;
    logic [c_fw-1:0] r_fcnt [2];

    state_t          r_state, w_state_n;
    logic [3:0]      r_cnt, w_cnt_n;
    logic [c_sw-1:0] r_shift, w_shift_n;
    logic [PTRW-1:0] r_ptr, w_ptr_n;
    logic [7:0]      r_wr_data, w_wr_data_n;
    logic            r_sda_oe, w_sda_oe_n;
    logic            r_scl_oe, w_scl_oe_n;
    logic            r_sel, w_sel_n;
    logic            r_wr_en, w_wr_en_n;
    logic            r_rd_en, w_rd_en_n;
    logic            r_rw, w_rw_n;
    logic            r_mack, w_mack_n;
    logic            r_load, w_load_n;

    logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [3:0] w_rx_len;

    // Synchronise pads, then accept a new level only after FILTER equal samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 2'b11;
            r_sync2   <= 2'b11;
            r_filt    <= 2'b11;
            r_prev    <= 2'b11;
            r_fcnt[0] <= '0;
            r_fcnt[1] <= '0;
        end else begin
            r_sync1 <= {scl_in, sda_in};
            r_sync2 <= r_sync1;
            r_prev  <= r_filt;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == c_fmax) begin
                    r_filt[i] <= r_sync2[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_scl      = r_filt[1];
    assign w_sda      = r_filt[0];
    assign w_scl_rise = w_scl & ~r_prev[1];
    assign w_scl_fall = ~w_scl & r_prev[1];
    assign w_start    = w_scl & r_prev[1] & r_prev[0] & ~w_sda;
    assign w_stop     = w_scl & r_prev[1] & ~r_prev[0] & w_sda;
    assign w_rx_len   = (r_state == S_ADDR) ? c_addr_bits : 4'd8;

    // Protocol state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_ptr     <= '0;
            r_wr_data <= '0;
            r_sda_oe  <= 1'b0;
            r_scl_oe  <= 1'b0;
            r_sel     <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rw      <= 1'b0;
            r_mack    <= 1'b0;
            r_load    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_shift   <= w_shift_n;
            r_ptr     <= w_ptr_n;
            r_wr_data <= w_wr_data_n;
            r_sda_oe  <= w_sda_oe_n;
            r_scl_oe  <= w_scl_oe_n;
            r_sel     <= w_sel_n;
            r_wr_en   <= w_wr_en_n;
            r_rd_en   <= w_rd_en_n;
            r_rw      <= w_rw_n;
            r_mack    <= w_mack_n;
            r_load    <= w_load_n;
        end
    end

    // Next-state and output decode; bus conditions take priority over everything
    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_shift_n   = r_shift;
        w_ptr_n     = r_ptr;
        w_wr_data_n = r_wr_data;
        w_sda_oe_n  = r_sda_oe;
        w_scl_oe_n  = r_scl_oe;
        w_sel_n     = r_sel;
        w_wr_en_n   = 1'b0;
        w_rd_en_n   = 1'b0;
        w_rw_n      = r_rw;
        w_mack_n    = r_mack;
        // Read data is valid the cycle after the request, so load one cycle later
        w_load_n    = r_rd_en;
        if (w_start) begin
            w_state_n  = S_ADDR;
            w_cnt_n    = '0;
            w_sel_n    = 1'b0;
            w_sda_oe_n = 1'b0;
            w_scl_oe_n = 1'b0;
            w_load_n   = 1'b0;
        end else if (w_stop) begin
            w_state_n  = S_IDLE;
            w_sel_n    = 1'b0;
            w_sda_oe_n = 1'b0;
            w_scl_oe_n = 1'b0;
            w_load_n   = 1'b0;
        end else begin
            case (r_state)
                S_ADDR, S_PTR, S_WRITE: begin
                    if (w_scl_rise) begin
                        w_shift_n = {r_shift[c_sw-2:0], w_sda};
                        w_cnt_n   = r_cnt + 4'd1;
                    end else if (w_scl_fall && r_cnt == w_rx_len) begin
                        w_cnt_n = '0;
                        if (r_state == S_ADDR) begin
                            if (r_shift[ADDRESSLENGTH:1] == SLAVE_ADDR) begin
                                w_rw_n     = r_shift[0];
                                w_sel_n    = 1'b1;
                                w_sda_oe_n = 1'b1;
                                w_state_n  = S_ACK_ADDR;
                            end else begin
                                w_state_n = S_IDLE;
                            end
                        end else if (r_state == S_PTR) begin
                            w_ptr_n    = r_shift[PTRW-1:0];
                            w_sda_oe_n = 1'b1;
                            w_state_n  = S_ACK_PTR;
                        end else begin
                            w_wr_en_n   = 1'b1;
                            w_wr_data_n = r_shift[7:0];
                            w_sda_oe_n  = 1'b1;
                            w_state_n   = S_ACK_WR;
                        end
                    end
                end
                S_ACK_ADDR, S_ACK_PTR, S_ACK_WR: begin
                    if (w_scl_fall) begin
                        w_sda_oe_n = 1'b0;
                        w_cnt_n    = '0;
                        if (r_state == S_ACK_ADDR && r_rw) begin
                            w_rd_en_n  = 1'b1;
                            w_scl_oe_n = c_stretch;
                            w_state_n  = S_READ;
                        end else if (r_state == S_ACK_ADDR) begin
                            w_state_n = S_PTR;
                        end else begin
                            if (r_state == S_ACK_WR) begin
                                w_ptr_n = r_ptr + 1'b1;
                            end
                            w_state_n = S_WRITE;
                        end
                    end
                end
                S_READ: begin
                    if (r_load) begin
                        w_shift_n      = '0;
                        w_shift_n[7:0] = reg_rd_data;
                        w_sda_oe_n     = ~reg_rd_data[7];
                        w_scl_oe_n     = 1'b0;
                        w_cnt_n        = '0;
                    end else if (w_scl_rise) begin
                        w_cnt_n = r_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_cnt == 4'd8) begin
                            w_sda_oe_n = 1'b0;
                            w_state_n  = S_MACK;
                        end else begin
                            w_shift_n  = r_shift << 1;
                            w_sda_oe_n = ~r_shift[6];
                        end
                    end
                end
                S_MACK: begin
                    if (w_scl_rise) begin
                        w_mack_n = w_sda;
                    end else if (w_scl_fall) begin
                        if (!r_mack) begin
                            w_ptr_n    = r_ptr + 1'b1;
                            w_rd_en_n  = 1'b1;
                            w_scl_oe_n = c_stretch;
                            w_cnt_n    = '0;
                            w_state_n  = S_READ;
                        end else begin
                            w_state_n = S_WAIT;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sda_oe      = r_sda_oe;
    assign scl_oe      = r_scl_oe;
    assign reg_addr    = r_ptr;
    assign reg_wr_data = r_wr_data;
    assign reg_wr_en   = r_wr_en;
    assign reg_rd_en   = r_rd_en;
    assign selected    = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave_regfile
// Brief    : Bus-level I2C master plus transaction-level register model for
//            i2c_slave_regfile; directed scenarios followed by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_regfile;

    localparam int T = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic m_scl = 1'b1, m_sda = 1'b1, glitch = 1'b0, glitch_req = 1'b0;
    logic tb_init = 1'b1;
    logic quiet = 1'b0;
    logic sda_oe, scl_oe, reg_wr_en, reg_rd_en, selected;
    logic [3:0] reg_addr;
    logic [7:0] reg_wr_data;
    logic [7:0] reg_rd_data = 8'h00;
    logic scl_bus, sda_bus, sda_pad;

    logic [7:0]  regbank [16];
    logic [7:0]  model_mem [16];
    logic [7:0]  wbuf [4];
    logic [7:0]  rbuf [4];
    logic [11:0] exp_wr [$];
    logic [3:0]  exp_rd [$];
    int total = 0;
    int bad = 0;
    int stretch_cnt = 0;
    logic scl_oe_q = 1'b0;

    assign scl_bus = m_scl & ~scl_oe;
    assign sda_bus = m_sda & ~sda_oe;
    assign sda_pad = sda_bus & ~glitch;

    always #5 clk = ~clk;

    i2c_slave_regfile dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scl_in      (scl_bus),
        .sda_in      (sda_pad),
        .sda_oe      (sda_oe),
        .scl_oe      (scl_oe),
        .reg_addr    (reg_addr),
        .reg_wr_data (reg_wr_data),
        .reg_wr_en   (reg_wr_en),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_data (reg_rd_data),
        .selected    (selected)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // External register file: one-cycle read latency
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 16; i++) regbank[i] <= 8'(i * 29 + 90);
        end else begin
            if (reg_wr_en) regbank[reg_addr] <= reg_wr_data;
            if (reg_rd_en) reg_rd_data <= regbank[reg_addr];
        end
    end

    // Compare process: strobes against model queues, quiet windows, stretch pulses
    always @(negedge clk) begin
        logic [11:0] ew;
        logic [3:0]  er;
        if (rst_n) begin
            if (reg_wr_en) begin
                check("wr_rd_exclusive", 32'(reg_rd_en), 32'd0);
                if (exp_wr.size() == 0) check("wr_unexpected", 32'(reg_wr_en), 32'd0);
                else begin
                    ew = exp_wr.pop_front();
                    check("wr_addr", 32'(reg_addr), 32'(ew[11:8]));
                    check("wr_data", 32'(reg_wr_data), 32'(ew[7:0]));
                end
            end
            if (reg_rd_en) begin
                if (exp_rd.size() == 0) check("rd_unexpected", 32'(reg_rd_en), 32'd0);
                else begin
                    er = exp_rd.pop_front();
                    check("rd_addr", 32'(reg_addr), 32'(er));
                end
            end
            if (quiet) check("quiet_outputs", 32'({sda_oe, scl_oe, reg_wr_en, reg_rd_en, selected}), 32'd0);
            if (scl_oe && !scl_oe_q) stretch_cnt++;
            scl_oe_q = scl_oe;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic release_scl();
        int k;
        k = 0;
        m_scl = 1'b1;
        @(negedge clk);
        while (scl_bus !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (k >= 400) check("scl_release_timeout", 32'(scl_bus), 32'd1);
    endtask

    task automatic start_cond();
        m_sda = 1'b1; wait_clks(T/2);
        release_scl(); wait_clks(T/2);
        m_sda = 1'b0; wait_clks(T/2);
        m_scl = 1'b0; wait_clks(T/2);
    endtask

    task automatic stop_cond();
        m_sda = 1'b0; wait_clks(T/2);
        release_scl(); wait_clks(T/2);
        m_sda = 1'b1; wait_clks(T);
    endtask

    task automatic write_bit(input logic b);
        m_sda = b; wait_clks(T/2);
        release_scl();
        if (glitch_req && b) begin
            wait_clks(T/4);
            glitch = 1'b1;
            @(negedge clk);
            glitch = 1'b0;
            glitch_req = 1'b0;
            wait_clks(T - T/4 - 1);
        end else begin
            wait_clks(T);
        end
        m_scl = 1'b0; wait_clks(T/2);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; wait_clks(T/2);
        release_scl(); wait_clks(T/2);
        b = sda_bus; wait_clks(T/2);
        m_scl = 1'b0; wait_clks(T/2);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    // Model: pointer = low 4 bits of pointer byte, each data byte lands at pointer, then pointer+1 mod 16
    task automatic do_write(input int ptr, input int n);
        logic a;
        int p;
        start_cond();
        write_byte(8'h84, a);
        check("ack_addr_w", 32'(a), 32'd0);
        check("selected_after_ack", 32'(selected), 32'd1);
        write_byte(8'(ptr), a);
        check("ack_ptr", 32'(a), 32'd0);
        p = ptr % 16;
        for (int i = 0; i < n; i++) begin
            exp_wr.push_back({4'(p), wbuf[i]});
            model_mem[p] = wbuf[i];
            write_byte(wbuf[i], a);
            check("ack_data", 32'(a), 32'd0);
            p = (p + 1) % 16;
        end
        stop_cond();
        check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
        check("selected_after_stop", 32'(selected), 32'd0);
    endtask

    task automatic do_read(input int ptr, input int n);
        logic a;
        int p, s0;
        start_cond();
        write_byte(8'h84, a);
        check("ack_addr_w", 32'(a), 32'd0);
        write_byte(8'(ptr), a);
        check("ack_ptr", 32'(a), 32'd0);
        start_cond();
        p = ptr % 16;
        for (int i = 0; i < n; i++) exp_rd.push_back(4'((p + i) % 16));
        s0 = stretch_cnt;
        write_byte(8'h85, a);
        check("ack_addr_r", 32'(a), 32'd0);
        check("selected_after_ack", 32'(selected), 32'd1);
        for (int i = 0; i < n; i++) begin
            read_byte(rbuf[i], (i == n - 1));
            check("rd_data", 32'(rbuf[i]), 32'(model_mem[(p + i) % 16]));
        end
        stop_cond();
        check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
        check("stretch_pulses", 32'(stretch_cnt - s0), 32'(n));
        check("selected_after_stop", 32'(selected), 32'd0);
    endtask

    task automatic do_nomatch(input logic [7:0] dev);
        logic a;
        quiet = 1'b1;
        start_cond();
        write_byte(dev, a);
        check("nack_addr", 32'(a), 32'd1);
        write_byte(8'hFF, a);
        check("nack_data", 32'(a), 32'd1);
        stop_cond();
        quiet = 1'b0;
    endtask

    initial begin
        #980000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic a, b;
        int kind, n, p, a7;
        for (int i = 0; i < 16; i++) model_mem[i] = 8'(i * 29 + 90);
        wait_clks(4);
        tb_init = 1'b0;
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_scl_oe", 32'(scl_oe), 32'd0);
        check("rst_reg_addr", 32'(reg_addr), 32'd0);
        check("rst_wr_data", 32'(reg_wr_data), 32'd0);
        check("rst_wr_en", 32'(reg_wr_en), 32'd0);
        check("rst_rd_en", 32'(reg_rd_en), 32'd0);
        check("rst_selected", 32'(selected), 32'd0);
        rst_n = 1'b1;
        wait_clks(10);

        // Burst write at 3,4
        wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
        do_write(3, 2);
        check("lit_reg3", 32'(regbank[3]), 32'hA5);
        check("lit_reg4", 32'(regbank[4]), 32'h5A);

        // Pointer wrap 15 -> 0
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        do_write(8'h0F, 2);
        check("lit_reg15", 32'(regbank[15]), 32'h11);
        check("lit_reg0", 32'(regbank[0]), 32'h22);

        // Read back through repeated START
        wbuf[0] = 8'hC3; wbuf[1] = 8'h3C;
        do_write(6, 2);
        do_read(6, 2);
        check("lit_rd0", 32'(rbuf[0]), 32'hC3);
        check("lit_rd1", 32'(rbuf[1]), 32'h3C);

        // Foreign device address
        do_nomatch(8'h86);

        // One-cycle Sda glitch while Scl high must not be taken as START
        glitch_req = 1'b1;
        wbuf[0] = 8'hFF; wbuf[1] = 8'h81;
        do_write(9, 2);
        check("lit_reg9", 32'(regbank[9]), 32'hFF);
        check("lit_reg10", 32'(regbank[10]), 32'h81);

        // Reset during 4th data bit of a read of 0xC3
        start_cond();
        write_byte(8'h84, a); check("rst_seq_ack_w", 32'(a), 32'd0);
        write_byte(8'h06, a); check("rst_seq_ack_p", 32'(a), 32'd0);
        start_cond();
        exp_rd.push_back(4'd6);
        write_byte(8'h85, a); check("rst_seq_ack_r", 32'(a), 32'd0);
        read_bit(b); check("rst_seq_bit7", 32'(b), 32'd1);
        read_bit(b); check("rst_seq_bit6", 32'(b), 32'd1);
        read_bit(b); check("rst_seq_bit5", 32'(b), 32'd0);
        m_sda = 1'b1; wait_clks(T/2);
        release_scl(); wait_clks(T/4);
        check("pre_reset_sda_oe", 32'(sda_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_sda_oe", 32'(sda_oe), 32'd0);
        check("async_rst_scl_oe", 32'(scl_oe), 32'd0);
        check("async_rst_selected", 32'(selected), 32'd0);
        m_scl = 1'b1; m_sda = 1'b1;
        wait_clks(4);
        rst_n = 1'b1;
        exp_rd.delete();
        wait_clks(20);
        wbuf[0] = 8'h77;
        do_write(2, 1);
        check("lit_reg2_after_rst", 32'(regbank[2]), 32'h77);

        // Random traffic
        for (int t = 0; t < 10; t++) begin
            kind = $urandom_range(0, 2);
            n = $urandom_range(1, 4);
            p = $urandom_range(0, 255);
            if (kind == 0) begin
                for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
                do_write(p, n);
            end else if (kind == 1) begin
                do_read(p, n);
            end else begin
                a7 = $urandom_range(0, 127);
                if (a7 == 32'h42) a7 = 32'h13;
                do_nomatch({7'(a7), 1'($urandom_range(0, 1))});
            end
        end

        check("final_wr_queue", 32'(exp_wr.size()), 32'd0);
        check("final_rd_queue", 32'(exp_rd.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
